// File: rtl/quantum_ctrl_pkg.sv
// Shared widths and FSM state encodings for the preemption quantum controller.
package quantum_ctrl_pkg;

    localparam int QUANTUM_W = 16;
    localparam int TIME_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

endpackage

// File: rtl/quantum_ctrl_if.sv
// OS-facing bus of the quantum controller: instruction retire pulse,
// quantum programming, context-switch handshake and status readback.
interface quantum_ctrl_if;
    import quantum_ctrl_pkg::*;

    logic                 done_inst;
    logic                 enable;
    logic                 set_quantum;
    logic [QUANTUM_W-1:0] quantum_in;
    logic                 ack;
    logic                 preempt_req;
    logic [QUANTUM_W-1:0] quantum_left;
    logic [TIME_W-1:0]    time_count;
    logic [1:0]           ctrl_state;

    modport master (
        output done_inst, enable, set_quantum, quantum_in, ack,
        input  preempt_req, quantum_left, time_count, ctrl_state
    );

    modport slave (
        input  done_inst, enable, set_quantum, quantum_in, ack,
        output preempt_req, quantum_left, time_count, ctrl_state
    );

endinterface

// File: rtl/quantum_ctrl_instr_timer.sv
// Free-running retired-instruction counter; wraps naturally at 2^W.
module instr_timer
    import quantum_ctrl_pkg::*;
#(
    parameter int W = TIME_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count one per enabled edge, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (en) count <= count + W'(1);
    end

endmodule

// File: rtl/quantum_ctrl.sv
// Time-slice controller: loads a quantum, counts retired instructions down
// and raises a level preemption request until the OS acknowledges it.
module quantum_ctrl
    import quantum_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    quantum_ctrl_if.slave  bus
);

    state_t               state, state_nxt;
    logic [QUANTUM_W-1:0] q_r;
    logic [QUANTUM_W-1:0] cnt, cnt_nxt;
    logic [QUANTUM_W-1:0] q_eff;
    logic                 preempt_r;
    logic [TIME_W-1:0]    tc;

    // A same-cycle set_quantum is the quantum every reload must see.
    assign q_eff = bus.set_quantum ? bus.quantum_in : q_r;

    // Next-state and down-counter update; enable drop outranks retirement.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.set_quantum) cnt_nxt = bus.quantum_in;
                if (bus.enable && q_eff != '0) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = q_eff;
                end
            end
            ST_RUN: begin
                if (!bus.enable) begin
                    state_nxt = ST_IDLE;
                    if (bus.set_quantum) cnt_nxt = bus.quantum_in;
                end else if (bus.set_quantum) begin
                    cnt_nxt = bus.quantum_in;
                    if (bus.quantum_in == '0) state_nxt = ST_IDLE;
                end else if (bus.done_inst) begin
                    if (cnt > QUANTUM_W'(1)) begin
                        cnt_nxt = cnt - QUANTUM_W'(1);
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = ST_EXPIRED;
                    end
                end
            end
            ST_EXPIRED: begin
                // Counter parks at zero; only the acknowledge leaves here.
                if (bus.ack) begin
                    cnt_nxt   = q_eff;
                    state_nxt = (bus.enable && q_eff != '0) ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, quantum, counter and registered preemption request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            q_r       <= '0;
            cnt       <= '0;
            preempt_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            q_r       <= q_eff;
            cnt       <= cnt_nxt;
            preempt_r <= (state_nxt == ST_EXPIRED);
        end
    end

    instr_timer #(.W(TIME_W)) u_timer (
        .clk   (clk),
        .rst   (reset),
        .en    (bus.done_inst),
        .count (tc)
    );

    assign bus.preempt_req  = preempt_r;
    assign bus.quantum_left = cnt;
    assign bus.time_count   = tc;
    assign bus.ctrl_state   = state;

endmodule

// File: tb/tb_quantum_ctrl.sv
// Directed bench for quantum_ctrl: a rule-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_quantum_ctrl;
    import quantum_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    quantum_ctrl_if bus ();

    quantum_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic chk_en = 1'b0;

    // Reference model: mode 0 idle, 1 running, 2 expired.
    int          m_mode;
    logic [15:0] m_q, m_cnt, m_qn;
    logic [31:0] m_tc;
    logic        m_pre;
    logic [31:0] preset_val = '0;
    int          preset_go  = 0;
    int          preset_ack = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_q = '0; m_cnt = '0; m_tc = '0; m_pre = 1'b0;
        end else begin
            if (preset_go != preset_ack) begin
                m_tc = preset_val;
                preset_ack = preset_go;
            end
            m_qn = bus.set_quantum ? bus.quantum_in : m_q;
            if (bus.done_inst) m_tc = m_tc + 32'd1;
            if (m_mode == 0) begin
                if (bus.set_quantum) m_cnt = bus.quantum_in;
                if (bus.enable && m_qn != 0) begin m_mode = 1; m_cnt = m_qn; end
            end else if (m_mode == 1) begin
                if (!bus.enable) begin
                    m_mode = 0;
                    if (bus.set_quantum) m_cnt = bus.quantum_in;
                end else if (bus.set_quantum) begin
                    m_cnt = bus.quantum_in;
                    if (bus.quantum_in == 0) m_mode = 0;
                end else if (bus.done_inst) begin
                    if (m_cnt > 1) m_cnt = m_cnt - 16'd1;
                    else begin m_cnt = '0; m_mode = 2; end
                end
            end else begin
                if (bus.ack) begin
                    m_cnt  = m_qn;
                    m_mode = (bus.enable && m_qn != 0) ? 1 : 0;
                end
            end
            m_q   = m_qn;
            m_pre = (m_mode == 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_state", 32'(bus.ctrl_state), 32'(m_mode));
            check("m_left",  32'(bus.quantum_left), 32'(m_cnt));
            check("m_time",  bus.time_count, m_tc);
            check("m_preq",  32'(bus.preempt_req), 32'(m_pre));
        end
    end

    task automatic cyc(input logic d, input logic s, input logic [15:0] qi, input logic a);
        bus.done_inst   = d;
        bus.set_quantum = s;
        bus.quantum_in  = qi;
        bus.ack         = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.done_inst = 0; bus.enable = 0; bus.set_quantum = 0;
        bus.quantum_in = '0; bus.ack = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        check("rst_state", 32'(bus.ctrl_state), 32'd0);
        check("rst_left",  32'(bus.quantum_left), 32'd0);
        check("rst_time",  bus.time_count, 32'd0);
        check("rst_preq",  32'(bus.preempt_req), 32'd0);

        // Quantum 3, three retirements expire the slice.
        bus.enable = 1;
        cyc(0, 1, 16'd3, 0);
        check("load_left", 32'(bus.quantum_left), 32'd3);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("pre_latency", 32'(bus.preempt_req), 32'd0);
        cyc(1, 0, 0, 0);
        check("exp_preq",  32'(bus.preempt_req), 32'd1);
        check("exp_left",  32'(bus.quantum_left), 32'd0);
        check("exp_time",  bus.time_count, 32'd3);
        check("exp_state", 32'(bus.ctrl_state), 32'd2);

        // Retirements while expired only count time; ack reloads.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        check("ack_time",  bus.time_count, 32'd5);
        check("ack_left",  32'(bus.quantum_left), 32'd3);
        check("ack_preq",  32'(bus.preempt_req), 32'd0);
        check("ack_state", 32'(bus.ctrl_state), 32'd1);

        // Reprogramming beats a same-cycle decrement.
        cyc(0, 1, 16'd5, 0);
        cyc(1, 1, 16'd10, 0);
        check("setdec_left", 32'(bus.quantum_left), 32'd10);
        check("setdec_time", bus.time_count, 32'd6);

        // Disable wins over retirement, then re-enable reloads Q.
        repeat (8) cyc(1, 0, 0, 0);
        check("cnt2_left", 32'(bus.quantum_left), 32'd2);
        bus.enable = 0;
        cyc(1, 0, 0, 0);
        check("dis_state", 32'(bus.ctrl_state), 32'd0);
        check("dis_left",  32'(bus.quantum_left), 32'd2);
        bus.enable = 1;
        cyc(0, 0, 0, 0);
        check("reen_left", 32'(bus.quantum_left), 32'd10);

        // Ack outside EXPIRED is ignored.
        cyc(0, 0, 0, 1);
        check("stray_ack", 32'(bus.ctrl_state), 32'd1);

        // Zero quantum parks the controller in IDLE.
        cyc(0, 1, 16'd0, 0);
        cyc(0, 0, 0, 0);
        check("q0_state", 32'(bus.ctrl_state), 32'd0);

        // set_quantum while expired; then set+ack reloads new value.
        cyc(0, 1, 16'd2, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 16'd7, 0);
        check("expset_state", 32'(bus.ctrl_state), 32'd2);
        check("expset_left",  32'(bus.quantum_left), 32'd0);
        cyc(0, 1, 16'd4, 1);
        check("setack_left",  32'(bus.quantum_left), 32'd4);
        check("setack_state", 32'(bus.ctrl_state), 32'd1);

        // Ack with enable low returns to IDLE holding Q.
        repeat (4) cyc(1, 0, 0, 0);
        bus.enable = 0;
        cyc(0, 0, 0, 1);
        check("ackidle_state", 32'(bus.ctrl_state), 32'd0);
        check("ackidle_left",  32'(bus.quantum_left), 32'd4);
        check("ackidle_time",  bus.time_count, 32'd21);

        // Time counter wrap.
        chk_en = 1'b0;
        force dut.u_timer.count = 32'hFFFF_FFFE;
        release dut.u_timer.count;
        preset_val = 32'hFFFF_FFFE;
        preset_go++;
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        check("wrap_max", bus.time_count, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0);
        check("wrap_zero", bus.time_count, 32'd0);

        // Asynchronous reset while expired.
        bus.enable = 1;
        cyc(0, 1, 16'd1, 0);
        cyc(1, 0, 0, 0);
        check("pre_rst_preq", 32'(bus.preempt_req), 32'd1);
        bus.ack = 1;
        #2 reset = 1'b1;
        #1;
        check("async_preq",  32'(bus.preempt_req), 32'd0);
        check("async_state", 32'(bus.ctrl_state), 32'd0);
        check("async_time",  bus.time_count, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.enable = 0;
        cyc(1, 0, 0, 0);
        check("post_rst_time", bus.time_count, 32'd1);
        cyc(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/quantum_ctrl.md
QUANTUM_CTRL -- requirements
Module: quantum_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: done_inst  input  1  one-cycle pulse from unit_control per completed instruction (state D).
REQ-004 SHALL have port: enable  input  1  preemption armed (level, driven by OS).
REQ-005 SHALL have port: set_quantum  input  1  load quantum_in into quantum register this cycle.
REQ-006 SHALL have port: quantum_in  input  16  new quantum, in instructions.
REQ-007 SHALL have port: ack  input  1  OS/BIOS acknowledge of context switch (one-cycle pulse).
REQ-008 SHALL have port: preempt_req  output  1  context-switch request, level, held until ack.
REQ-009 SHALL have port: quantum_left  output  16  remaining instructions in slice (GETQUANTUM source).
REQ-010 SHALL have port: time_count  output  32  instructions retired since reset (GETTIME source).
REQ-011 SHALL have port: ctrl_state  output  2  FSM state: IDLE=0, RUN=1, EXPIRED=2; 3 unused.

Function
REQ-012 SHALL keep a quantum register Q (16b) and a down-counter cnt (16b); quantum_left = cnt.
REQ-013 SHALL increment time_count by 1 on every posedge with done_inst=1, in every FSM state, wrapping 0xFFFFFFFF -> 0.
REQ-014 IDLE: cnt held; on enable=1 and Q!=0, next state RUN and cnt <= Q.
REQ-015 RUN: on done_inst with cnt>1, cnt <= cnt-1; on done_inst with cnt==1, cnt <= 0 and next state EXPIRED.
REQ-016 RUN: enable=0 SHALL move to IDLE with cnt held; checked before done_inst (enable=0 wins, no decrement).
REQ-017 EXPIRED: preempt_req=1 (registered, asserted first cycle in EXPIRED, latency 1 clk after final done_inst); cnt held at 0; done_inst does not touch cnt.
REQ-018 EXPIRED: on ack, cnt <= Q and next state RUN if enable=1 and Q!=0, else IDLE; preempt_req deasserts the cycle after ack.
REQ-019 ack outside EXPIRED SHALL be ignored.
REQ-020 set_quantum SHALL write Q <= quantum_in in any state; in IDLE/RUN also cnt <= quantum_in, with priority over done_inst decrement in the same cycle.
REQ-021 set_quantum with quantum_in=0 in RUN SHALL go to IDLE; in IDLE with Q=0 enable SHALL keep IDLE.
REQ-022 set_quantum in EXPIRED SHALL update Q only; state stays EXPIRED until ack; set_quantum and ack same cycle: reload uses quantum_in.
REQ-023 ctrl_state encoding 3 SHALL be unreachable; if entered, next state IDLE.

Reset
REQ-024 reset=1 SHALL asynchronously force: state IDLE, Q=0, cnt=0, time_count=0, preempt_req=0, ctrl_state=0.
REQ-025 reset asserted mid-slice or in EXPIRED SHALL drop preempt_req immediately; pending ack/done_inst discarded; first count after reset release on next posedge with done_inst=1.

Structure
REQ-026 SHALL place state encodings (IDLE/RUN/EXPIRED), QUANTUM_W=16 and TIME_W=32 in shared package quantum_ctrl_pkg.
REQ-027 SHALL instantiate one sub-module instr_timer (free-running 32b counter with enable and async reset) for time_count; FSM and cnt stay in quantum_ctrl.

Verification
REQ-028 Reset release, enable=1, set_quantum with 3, 3 done_inst pulses -> preempt_req=1 one clk after third pulse, quantum_left=0, time_count=3, ctrl_state=2.
REQ-029 In EXPIRED, 2 more done_inst then ack -> time_count=5, cnt reloaded to 3, preempt_req=0 next clk, ctrl_state=1.
REQ-030 RUN cnt=5, set_quantum(10) and done_inst same cycle -> quantum_left=10, time_count +1.
REQ-031 RUN cnt=2, enable=0 with done_inst -> IDLE, quantum_left=2; enable=1 -> RUN, quantum_left=Q.
REQ-032 time_count preset near 0xFFFFFFFF via 2^32-1 pulses (or forced) -> one more done_inst gives 0; reset during EXPIRED -> preempt_req=0 without clock edge.
